// File: rtl/z80_break_controller.sv
// Z80 breakpoint / single-step controller.
// Watches M1 fetches against four address slots and stalls the CPU via WAIT
// on a hit, a HALT command, or after one stepped fetch.
// Optional feature: define Z80_BRK_INSTR_COUNT_EN to build the fetch counter;
// otherwise instr_count is tied to zero.
module z80_break_controller (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        m1_n,
    input  logic [15:0] pc,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    input  logic        bp_we,
    input  logic [1:0]  bp_idx,
    input  logic [15:0] bp_addr,
    input  logic        bp_en,
    output logic        cpu_wait_n,
    output logic        halted,
    output logic        hit_valid,
    output logic [1:0]  hit_idx,
    output logic [15:0] hit_pc,
    output logic [31:0] instr_count
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned SLOTS = 4;
    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] CMD_RUN    = 2'd0;
    localparam logic [1:0] CMD_HALT   = 2'd1;
    localparam logic [1:0] CMD_STEP   = 2'd2;
    localparam logic [1:0] CMD_CLRHIT = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               hit_load;

    logic [PC_W-1:0]    slot_addr [SLOTS];
    logic [SLOTS-1:0]   slot_en;
    logic               m1_prev;

    logic               fe;
    logic               match;
    logic [IDX_W-1:0]   match_idx;
    logic               cmd_run;
    logic               cmd_halt;
    logic               cmd_step;
    logic               cmd_clr;

    logic               wait_n_nxt;
    logic               halted_nxt;
    logic               hit_valid_nxt;
    logic [IDX_W-1:0]   hit_idx_nxt;
    logic [PC_W-1:0]    hit_pc_nxt;

    // One fetch event per M1 cycle: falling M1 seen on an enabled CPU cycle
    assign fe       = ce && !m1_n && m1_prev;
    assign cmd_run  = cmd_valid && (cmd == CMD_RUN);
    assign cmd_halt = cmd_valid && (cmd == CMD_HALT);
    assign cmd_step = cmd_valid && (cmd == CMD_STEP);
    assign cmd_clr  = cmd_valid && (cmd == CMD_CLRHIT);

    // Lowest-numbered enabled slot whose address equals the current PC
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_en[i] && (slot_addr[i] == pc)) begin
                match     = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a breakpoint hit always wins over a same-cycle command
    always_comb begin
        state_nxt = state;
        hit_load  = 1'b0;
        case (state)
            ST_RUN: begin
                if (fe && match) begin
                    state_nxt = ST_HALTED;
                    hit_load  = 1'b1;
                end else if (cmd_halt) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (fe && match) begin
                    hit_load = 1'b1;
                end else if (cmd_run) begin
                    state_nxt = ST_RUN;
                end else if (cmd_step) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                if (cmd_halt || fe) begin
                    state_nxt = ST_HALTED;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        wait_n_nxt    = (state_nxt != ST_HALTED);
        halted_nxt    = (state_nxt == ST_HALTED);
        hit_valid_nxt = hit_valid;
        hit_idx_nxt   = hit_idx;
        hit_pc_nxt    = hit_pc;
        if (hit_load) begin
            hit_valid_nxt = 1'b1;
            hit_idx_nxt   = match_idx;
            hit_pc_nxt    = pc;
        end else if (cmd_clr) begin
            hit_valid_nxt = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cpu_wait_n <= 1'b1;
            halted     <= 1'b0;
            hit_valid  <= 1'b0;
            hit_idx    <= '0;
            hit_pc     <= '0;
        end else begin
            cpu_wait_n <= wait_n_nxt;
            halted     <= halted_nxt;
            hit_valid  <= hit_valid_nxt;
            hit_idx    <= hit_idx_nxt;
            hit_pc     <= hit_pc_nxt;
        end
    end

    // Previous M1 level, tracked only on CPU-enabled cycles
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            m1_prev <= 1'b1;
        end else if (ce) begin
            m1_prev <= m1_n;
        end
    end

    // Breakpoint slots; a same-cycle fetch compares against the old contents
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_addr[i] <= '0;
            end
            slot_en <= '0;
        end else if (bp_we) begin
            slot_addr[bp_idx] <= bp_addr;
            slot_en[bp_idx]   <= bp_en;
        end
    end

`ifdef Z80_BRK_INSTR_COUNT_EN
    logic [CNT_W-1:0] instr_cnt_q;

    // Count fetches that are allowed to proceed; wraps naturally
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            instr_cnt_q <= '0;
        end else if (fe && (state_nxt != ST_HALTED)) begin
            instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    assign instr_count = instr_cnt_q;
`else
    assign instr_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_z80_break_controller.sv
// Directed self-checking bench for z80_break_controller.
// Counter wrap checks run only when Z80_BRK_INSTR_COUNT_EN is defined.
module tb_z80_break_controller;

    logic        clk_sys;
    logic        reset_n;
    logic        ce;
    logic        m1_n;
    logic [15:0] pc;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        bp_we;
    logic [1:0]  bp_idx;
    logic [15:0] bp_addr;
    logic        bp_en;
    logic        cpu_wait_n;
    logic        halted;
    logic        hit_valid;
    logic [1:0]  hit_idx;
    logic [15:0] hit_pc;
    logic [31:0] instr_count;

    int tests_run;
    int tests_failed;

    z80_break_controller dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce          (ce),
        .m1_n        (m1_n),
        .pc          (pc),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .bp_we       (bp_we),
        .bp_idx      (bp_idx),
        .bp_addr     (bp_addr),
        .bp_en       (bp_en),
        .cpu_wait_n  (cpu_wait_n),
        .halted      (halted),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx),
        .hit_pc      (hit_pc),
        .instr_count (instr_count)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic command(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic write_slot(input logic [1:0] idx, input logic [15:0] addr, input logic en);
        bp_we   = 1'b1;
        bp_idx  = idx;
        bp_addr = addr;
        bp_en   = en;
        tick();
        bp_we   = 1'b0;
    endtask

    // Start an M1 cycle at address a; M1 stays low afterwards
    task automatic fe_at(input logic [15:0] a);
        m1_n = 1'b0;
        pc   = a;
        tick();
    endtask

    task automatic release_m1();
        m1_n = 1'b1;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n   = 1'b0;
        ce        = 1'b1;
        m1_n      = 1'b1;
        pc        = 16'h0000;
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        bp_we     = 1'b0;
        bp_idx    = 2'd0;
        bp_addr   = 16'h0000;
        bp_en     = 1'b0;
        tick();
        tick();

        check("rst_wait_n",    32'(cpu_wait_n),  32'h1);
        check("rst_halted",    32'(halted),      32'h0);
        check("rst_hit_valid", 32'(hit_valid),   32'h0);
        check("rst_hit_idx",   32'(hit_idx),     32'h0);
        check("rst_hit_pc",    32'(hit_pc),      32'h0);
        check("rst_count",     instr_count,      32'h0);
        reset_n = 1'b1;

        // Slot 0 at 0x0100; non-matching fetches run through
        write_slot(2'd0, 16'h0100, 1'b1);
        fe_at(16'h0000);
        check("run_0000", 32'(halted), 32'h0);
        release_m1();
        fe_at(16'h0003);
        check("run_0003", 32'(halted), 32'h0);
        release_m1();

        // M1 low with ce=0 is not a fetch; the first ce=1 cycle is
        ce   = 1'b0;
        m1_n = 1'b0;
        pc   = 16'h0100;
        tick();
        check("ce_gate", 32'(halted), 32'h0);
        ce = 1'b1;
        tick();
        check("bp0_halted",    32'(halted),     32'h1);
        check("bp0_wait_n",    32'(cpu_wait_n), 32'h0);
        check("bp0_hit_valid", 32'(hit_valid),  32'h1);
        check("bp0_hit_idx",   32'(hit_idx),    32'h0);
        check("bp0_hit_pc",    32'(hit_pc),     32'h0100);
        tick();
        check("bp0_stall", 32'(halted), 32'h1);

        // Single step: stalled fetch does not refetch, next fetch re-halts
        command(2'd2);
        check("step_halted", 32'(halted),     32'h0);
        check("step_wait_n", 32'(cpu_wait_n), 32'h1);
        tick();
        check("step_no_refetch", 32'(halted), 32'h0);
        release_m1();
        fe_at(16'h0101);
        check("step_done_halted", 32'(halted), 32'h1);
        check("step_hit_pc",      32'(hit_pc), 32'h0100);
        pc = 16'h0102;
        tick();
        check("step_stays", 32'(halted), 32'h1);

        command(2'd3);
        check("clr_hit_valid", 32'(hit_valid), 32'h0);
        check("clr_halted",    32'(halted),    32'h1);
        command(2'd0);
        check("resume_run", 32'(halted), 32'h0);
        release_m1();

        // Lowest matching slot wins
        write_slot(2'd1, 16'h2000, 1'b1);
        write_slot(2'd3, 16'h2000, 1'b1);
        fe_at(16'h2000);
        check("prio_halted",  32'(halted),  32'h1);
        check("prio_hit_idx", 32'(hit_idx), 32'h1);
        check("prio_hit_pc",  32'(hit_pc),  32'h2000);
        command(2'd0);
        release_m1();

        // Slot write concurrent with a fetch compares against old contents
        bp_we   = 1'b1;
        bp_idx  = 2'd1;
        bp_addr = 16'h3000;
        bp_en   = 1'b0;
        m1_n    = 1'b0;
        pc      = 16'h2000;
        tick();
        bp_we = 1'b0;
        check("old_slot_idx", 32'(hit_idx), 32'h1);
        command(2'd0);
        release_m1();

        // Slot 1 now disabled; hit overwrites the still-valid latch
        fe_at(16'h2000);
        check("dis_slot_idx",   32'(hit_idx),   32'h3);
        check("dis_slot_valid", 32'(hit_valid), 32'h1);
        command(2'd0);
        release_m1();

        // HALT command together with a matching fetch
        cmd_valid = 1'b1;
        cmd       = 2'd1;
        m1_n      = 1'b0;
        pc        = 16'h0100;
        tick();
        cmd_valid = 1'b0;
        check("halt_bp_halted", 32'(halted),    32'h1);
        check("halt_bp_valid",  32'(hit_valid), 32'h1);
        check("halt_bp_pc",     32'(hit_pc),    32'h0100);
        check("halt_bp_idx",    32'(hit_idx),   32'h0);
        command(2'd3);
        check("halt_clr_valid",  32'(hit_valid), 32'h0);
        check("halt_clr_halted", 32'(halted),    32'h1);
        command(2'd0);
        release_m1();

        // Plain HALT command leaves hit fields untouched
        command(2'd1);
        check("cmd_halt_halted", 32'(halted),    32'h1);
        check("cmd_halt_valid",  32'(hit_valid), 32'h0);
        check("cmd_halt_pc",     32'(hit_pc),    32'h0100);
        command(2'd0);
        check("cmd_run_halted", 32'(halted), 32'h0);

        // STEP is meaningless in RUN and must not arm a step
        command(2'd2);
        fe_at(16'h0050);
        check("step_in_run_ignored", 32'(halted), 32'h0);
        release_m1();

        // STEP with a matching fetch: hit latched, command dropped
        cmd_valid = 1'b1;
        cmd       = 2'd2;
        m1_n      = 1'b0;
        pc        = 16'h0100;
        tick();
        cmd_valid = 1'b0;
        check("step_bp_halted", 32'(halted),    32'h1);
        check("step_bp_valid",  32'(hit_valid), 32'h1);
        tick();
        check("step_bp_dropped", 32'(halted), 32'h1);

        // HALT while stepping
        command(2'd2);
        release_m1();
        check("in_step", 32'(halted), 32'h0);
        command(2'd1);
        check("step_cmd_halt", 32'(halted), 32'h1);

        // Stepped fetch ignores breakpoint matches
        command(2'd3);
        command(2'd2);
        fe_at(16'h0100);
        check("step_ign_halted", 32'(halted),    32'h1);
        check("step_ign_valid",  32'(hit_valid), 32'h0);
`ifndef Z80_BRK_INSTR_COUNT_EN
        check("count_tied_zero", instr_count, 32'h0);
`endif

        // Reset mid-STEP with a hit latched
        command(2'd0);
        release_m1();
        fe_at(16'h0100);
        check("pre_rst_valid", 32'(hit_valid), 32'h1);
        command(2'd2);
        check("pre_rst_step", 32'(halted), 32'h0);
        reset_n = 1'b0;
        tick();
        check("rst2_wait_n",    32'(cpu_wait_n), 32'h1);
        check("rst2_halted",    32'(halted),     32'h0);
        check("rst2_hit_valid", 32'(hit_valid),  32'h0);
        check("rst2_hit_idx",   32'(hit_idx),    32'h0);
        check("rst2_hit_pc",    32'(hit_pc),     32'h0);
        check("rst2_count",     instr_count,     32'h0);
        reset_n = 1'b1;
        release_m1();

        // Slots cleared by reset: address 0 must not match
        fe_at(16'h0000);
        check("slots_cleared", 32'(halted), 32'h0);
        release_m1();

`ifdef Z80_BRK_INSTR_COUNT_EN
        check("count_one", instr_count, 32'h1);
        force dut.instr_cnt_q = 32'hFFFF_FFFE;
        tick();
        release dut.instr_cnt_q;
        check("count_preload", instr_count, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            fe_at(16'h0010);
            release_m1();
        end
        check("count_wrap", instr_count, 32'h0000_0001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/z80_break_controller.md
Z80_BREAK_CONTROLLER -- requirements
Module: z80_break_controller

Interface
REQ-001 SHALL provide port clk_sys, input, 1 bit: system clock; all logic on its rising edge.
REQ-002 SHALL provide port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL provide port ce, input, 1 bit: CPU chip enable; fetch detection only in cycles with ce=1.
REQ-004 SHALL provide port m1_n, input, 1 bit: CPU M1 fetch strobe, active-low.
REQ-005 SHALL provide port pc, input, 16 bits: current program counter, i.e. register-set bits 79:64.
REQ-006 SHALL provide port cmd_valid, input, 1 bit: command strobe, one cycle.
REQ-007 SHALL provide port cmd, input, 2 bits: 0=RUN, 1=HALT, 2=STEP, 3=CLRHIT.
REQ-008 SHALL provide port bp_we, input, 1 bit: breakpoint slot write strobe.
REQ-009 SHALL provide port bp_idx, input, 2 bits: slot select, 0-3.
REQ-010 SHALL provide port bp_addr, input, 16 bits: slot address.
REQ-011 SHALL provide port bp_en, input, 1 bit: slot enable.
REQ-012 SHALL provide port cpu_wait_n, output, 1 bit: CPU WAIT, low stalls the CPU.
REQ-013 SHALL provide port halted, output, 1 bit: controller is in HALTED.
REQ-014 SHALL provide port hit_valid, output, 1 bit: a breakpoint hit is latched.
REQ-015 SHALL provide port hit_idx, output, 2 bits: slot of the latched hit.
REQ-016 SHALL provide port hit_pc, output, 16 bits: PC of the latched hit.
REQ-017 SHALL provide port instr_count, output, 32 bits: count of fetches executed.

Function
REQ-018 Fetch event (FE) SHALL be: ce=1, m1_n=0, and the m1_n value registered on the previous ce=1 cycle equal to 1; exactly one FE per M1 cycle.
REQ-019 State machine SHALL have states RUN, HALTED and STEP.
REQ-020 cpu_wait_n SHALL be registered: low in HALTED, high in RUN and STEP.
REQ-021 In RUN, an FE with pc equal to the address of any enabled slot SHALL cause, next cycle: state=HALTED, hit_valid=1, hit_idx=lowest matching slot, hit_pc=pc.
REQ-022 In RUN, cmd HALT SHALL go to HALTED next cycle; hit fields unchanged.
REQ-023 In HALTED, cmd RUN SHALL go to RUN; cmd STEP SHALL go to STEP; the fetch already stalled SHALL NOT produce a second FE.
REQ-024 In STEP, the first FE SHALL return to HALTED next cycle, ignoring breakpoint matches.
REQ-025 In STEP, cmd HALT SHALL go to HALTED immediately.
REQ-026 cmd CLRHIT SHALL clear hit_valid in any state; state unchanged.
REQ-027 A new hit SHALL overwrite hit fields even when hit_valid=1.
REQ-028 A breakpoint match and cmd HALT in the same cycle SHALL go to HALTED with the hit latched.
REQ-029 A breakpoint match and cmd RUN or STEP in the same cycle SHALL go to HALTED with the hit latched; the command is dropped.
REQ-030 Commands not listed for the current state SHALL be ignored.
REQ-031 bp_we SHALL write bp_addr and bp_en to slot bp_idx next cycle.
REQ-032 A slot write in the same cycle as an FE SHALL compare against the old slot contents.
REQ-033 Slots with enable=0 SHALL never match.

Reset
REQ-034 reset_n=0 at a clock edge SHALL set: state=RUN, cpu_wait_n=1, halted=0, hit_valid=0, hit_idx=0, hit_pc=0, instr_count=0, all slots address=0 and disabled, previous-m1_n register=1.
REQ-035 Reset asserted while HALTED or STEP SHALL release the CPU (cpu_wait_n=1) on the following cycle.

Configuration
REQ-036 Macro Z80_BRK_INSTR_COUNT_EN defined SHALL make instr_count increment by 1 on each FE that does not cause a halt, wrapping 0xFFFFFFFF->0.
REQ-037 Macro Z80_BRK_INSTR_COUNT_EN undefined SHALL tie instr_count to 0 and build no counter.

Verification
REQ-038 Reset, slot0=0x0100 enabled, fetches 0x0000/0x0003/0x0100 -> halted=1 and cpu_wait_n=0 cycle after 0x0100 FE, hit_idx=0, hit_pc=0x0100.
REQ-039 Slots 1 and 3 both 0x2000 enabled, FE at 0x2000 -> hit_idx=1.
REQ-040 HALTED, cmd STEP, fetches 0x0101/0x0102 -> exactly one FE passes, HALTED after 0x0101 FE, hit_pc unchanged.
REQ-041 RUN, cmd HALT on same cycle as matching FE at 0x0100 -> HALTED, hit_valid=1, hit_pc=0x0100; then CLRHIT -> hit_valid=0, halted=1.
REQ-042 With counter enabled, preload near wrap, 3 FEs from 0xFFFFFFFE -> 0x00000001; reset_n low mid-STEP -> all outputs at reset values next cycle.
